// File: rtl/tt_proj_mux_ctrl.sv
// Project mux controller: synchronizes the control pads, keeps the project-select
// counter, enables exactly one wrapper with a guard gap on every selection change,
// broadcasts the input bundle and returns the selected wrapper's output bundle.
module tt_proj_mux_ctrl #(
  parameter int unsigned N_PROJ    = 24,
  parameter int unsigned SEL_W     = 5,
  parameter int unsigned IW_W      = 18,
  parameter int unsigned OW_W      = 24,
  parameter int unsigned GUARD_CYC = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ctrl_sel_rst,
  input  logic                     ctrl_sel_inc,
  input  logic                     ctrl_ena,
  input  logic [IW_W-1:0]          spine_iw,
  output logic [OW_W-1:0]          spine_ow,
  output logic [N_PROJ-1:0]        proj_ena,
  output logic [IW_W-1:0]          proj_iw,
  input  logic [N_PROJ*OW_W-1:0]   proj_ow,
  output logic [SEL_W-1:0]         sel,
  output logic                     active
);

  localparam int unsigned GcntW     = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
  localparam int unsigned GcntLastI = (GUARD_CYC == 0) ? 0 : GUARD_CYC - 1;
  localparam logic [GcntW-1:0] GcntLast = GcntW'(GcntLastI);
  localparam logic [SEL_W-1:0] SelLast  = SEL_W'(N_PROJ - 1);

  typedef enum logic [1:0] {StOff, StGuard, StOn} state_e;

  // Two-flop synchronizers; bit 1 is the synchronized value.
  logic [1:0] rst_sync_q, inc_sync_q, ena_sync_q;
  logic       inc_s_q;
  logic       sel_rst_s, inc_s, ena_s, inc_edge;

  logic [SEL_W-1:0]  sel_q, sel_d, sel_last_q, cur_q, cur_d;
  logic [GcntW-1:0]  gcnt_q, gcnt_d;
  state_e            state_q, state_d;
  logic [N_PROJ-1:0] proj_ena_q, proj_ena_d;
  logic [IW_W-1:0]   proj_iw_q, proj_iw_d;
  logic [OW_W-1:0]   spine_ow_q, spine_ow_d;
  logic              sel_chg;

  assign sel_rst_s = rst_sync_q[1];
  assign inc_s     = inc_sync_q[1];
  assign ena_s     = ena_sync_q[1];
  assign inc_edge  = inc_s & ~inc_s_q;
  // Selection moved on the last edge; used to restart the guard count.
  assign sel_chg   = (sel_q != sel_last_q);

  // Pad synchronizers and the inc edge-detect delay.
  always_ff @(posedge clk) begin
    if (rst) begin
      rst_sync_q <= '0;
      inc_sync_q <= '0;
      ena_sync_q <= '0;
      inc_s_q    <= 1'b0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], ctrl_sel_rst};
      inc_sync_q <= {inc_sync_q[0], ctrl_sel_inc};
      ena_sync_q <= {ena_sync_q[0], ctrl_ena};
      inc_s_q    <= inc_s;
    end
  end

  // Select counter: clear wins over increment, wraps at N_PROJ-1.
  always_comb begin
    sel_d = sel_q;
    if (sel_rst_s) begin
      sel_d = '0;
    end else if (inc_edge) begin
      sel_d = (sel_q == SelLast) ? '0 : sel_q + 1'b1;
    end
  end

  // FSM next state: dropping enable always wins, then selection changes.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    gcnt_d  = gcnt_q;
    unique case (state_q)
      StOff: begin
        if (ena_s) begin
          state_d = StGuard;
          gcnt_d  = '0;
        end
      end
      StGuard: begin
        if (!ena_s) begin
          state_d = StOff;
        end else if (sel_chg) begin
          gcnt_d = '0;
        end else if (gcnt_q == GcntLast) begin
          state_d = StOn;
          cur_d   = sel_q;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      StOn: begin
        if (!ena_s) begin
          state_d = StOff;
        end else if (sel_q != cur_q) begin
          state_d = StGuard;
          gcnt_d  = '0;
        end
      end
      default: state_d = StOff;
    endcase
  end

  // Output next values: everything forced to zero unless ON.
  always_comb begin
    proj_ena_d = '0;
    proj_iw_d  = '0;
    spine_ow_d = '0;
    if (state_q == StOn) begin
      proj_ena_d = N_PROJ'(1) << cur_q;
      proj_iw_d  = spine_iw;
      spine_ow_d = proj_ow[32'(cur_q) * OW_W +: OW_W];
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StOff;
      sel_q      <= '0;
      sel_last_q <= '0;
      cur_q      <= '0;
      gcnt_q     <= '0;
      proj_ena_q <= '0;
      proj_iw_q  <= '0;
      spine_ow_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      sel_last_q <= sel_q;
      cur_q      <= cur_d;
      gcnt_q     <= gcnt_d;
      proj_ena_q <= proj_ena_d;
      proj_iw_q  <= proj_iw_d;
      spine_ow_q <= spine_ow_d;
    end
  end

  assign proj_ena = proj_ena_q;
  assign proj_iw  = proj_iw_q;
  assign spine_ow = spine_ow_q;
  assign sel      = sel_q;
  assign active   = (state_q == StOn);

endmodule
